// File: rtl/mac_parallel_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_parallel_ctrl_pkg : shared state encoding and size defaults        |
// | Revision 1.0                                                           |
// +----------------------------------------------------------------------+
package mac_parallel_ctrl_pkg;

    localparam int CNT_WIDTH_DEF  = 16;
    localparam int PERF_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mac_parallel_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_parallel_ctrl_if : job, chunk, MAC-control and done handshake bus  |
// | Revision 1.0                                                           |
// +----------------------------------------------------------------------+
interface mac_parallel_ctrl_if
    import mac_parallel_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int PERF_WIDTH = PERF_WIDTH_DEF
) ();

    logic                  start;
    logic [CNT_WIDTH-1:0]  num_chunks;
    logic                  load_init;
    logic                  busy;
    logic                  in_valid;
    logic                  in_ready;
    logic                  mac_en;
    logic                  mac_load_accum;
    logic                  mac_reset;
    logic                  done_valid;
    logic                  done_ready;
    logic [PERF_WIDTH-1:0] perf_busy_cycles;
    logic [PERF_WIDTH-1:0] perf_stall_cycles;

    modport master (
        output start, num_chunks, load_init, in_valid, done_ready,
        input  busy, in_ready, mac_en, mac_load_accum, mac_reset, done_valid,
        input  perf_busy_cycles, perf_stall_cycles
    );

    modport slave (
        input  start, num_chunks, load_init, in_valid, done_ready,
        output busy, in_ready, mac_en, mac_load_accum, mac_reset, done_valid,
        output perf_busy_cycles, perf_stall_cycles
    );

endinterface
`default_nettype wire

// File: rtl/mac_parallel_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_parallel_ctrl : sequences chunked MAC jobs (IDLE/RUN/DRAIN/DONE).  |
// | Optional perf counters enabled by MAC_CTRL_PERF_CNT_EN.                |
// | Revision 1.0                                                           |
// +----------------------------------------------------------------------+
module mac_parallel_ctrl
    import mac_parallel_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int PERF_WIDTH = PERF_WIDTH_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    mac_parallel_ctrl_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 load_init_q, load_init_d;
    logic                 first_q, first_d;

    logic w_run;
    logic w_accept;
    logic w_mac_en;

    assign w_run    = (state_q == RUN);
    assign w_accept = w_run && bus.in_valid;
    assign w_mac_en = w_accept || (state_q == DRAIN);

    assign bus.in_ready       = w_run;
    assign bus.mac_en         = w_mac_en;
    assign bus.mac_reset      = (state_q == IDLE);
    assign bus.busy           = (state_q != IDLE);
    assign bus.done_valid     = (state_q == DONE);
    // first_q marks the job's first MAC-enable cycle, where the seed is taken
    assign bus.mac_load_accum = w_mac_en && first_q && load_init_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_init_d = load_init_q;
        first_d     = first_q;
        if (w_mac_en) begin
            first_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_d       = bus.num_chunks;
                    load_init_d = bus.load_init;
                    first_d     = 1'b1;
                    state_d     = (bus.num_chunks == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (bus.in_valid) begin
                    cnt_d = cnt_q - C_CNT_ONE;
                    if (cnt_q == C_CNT_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                if (bus.done_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            load_init_q <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            load_init_q <= load_init_d;
            first_q     <= first_d;
        end
    end

`ifdef MAC_CTRL_PERF_CNT_EN
    localparam logic [PERF_WIDTH-1:0] C_PERF_ONE = {{(PERF_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PERF_WIDTH-1:0] C_PERF_MAX = {PERF_WIDTH{1'b1}};

    logic [PERF_WIDTH-1:0] perf_busy_q, perf_busy_d;
    logic [PERF_WIDTH-1:0] perf_stall_q, perf_stall_d;

    // Both counters stick at all-ones rather than wrapping
    always_comb begin
        perf_busy_d  = perf_busy_q;
        perf_stall_d = perf_stall_q;
        if ((state_q != IDLE) && (perf_busy_q != C_PERF_MAX)) begin
            perf_busy_d = perf_busy_q + C_PERF_ONE;
        end
        if (w_run && !bus.in_valid && (perf_stall_q != C_PERF_MAX)) begin
            perf_stall_d = perf_stall_q + C_PERF_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_busy_q  <= perf_busy_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign bus.perf_busy_cycles  = perf_busy_q;
    assign bus.perf_stall_cycles = perf_stall_q;
`else
    assign bus.perf_busy_cycles  = {PERF_WIDTH{1'b0}};
    assign bus.perf_stall_cycles = {PERF_WIDTH{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_mac_parallel_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mac_parallel_ctrl : directed jobs through a reference 16-lane MAC   |
// | Revision 1.0                                                           |
// +----------------------------------------------------------------------+
module tb_mac_parallel_ctrl;

    localparam int VEC_LENGTH = 16;
`ifdef MAC_CTRL_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    typedef struct {
        string       nm;
        logic [63:0] act;
        logic [63:0] exp;
    } obs_t;

    typedef struct {
        logic [63:0] acc;
        int          lat;
        int          ld;
        longint      pstall;
        longint      pbusy;
    } job_t;

    logic clk;
    logic reset_n;

    mac_parallel_ctrl_if #(.CNT_WIDTH(16), .PERF_WIDTH(32)) bus ();

    mac_parallel_ctrl #(.CNT_WIDTH(16), .PERF_WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference MAC: one product pipeline stage feeding the accumulator
    logic [7:0]  act_v [VEC_LENGTH];
    logic [7:0]  wgt_v [VEC_LENGTH];
    logic [31:0] accum_prev;
    logic [31:0] dot;
    logic [31:0] prod_q;
    logic [31:0] acc_q;

    always_comb begin
        dot = '0;
        for (int i = 0; i < VEC_LENGTH; i++) begin
            dot = dot + (32'(act_v[i]) * 32'(wgt_v[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (bus.mac_reset) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else if (bus.mac_en) begin
            prod_q <= dot;
            acc_q  <= (bus.mac_load_accum ? accum_prev : acc_q) + prod_q;
        end
    end

    // Scoreboard state
    obs_t obs_q[$];
    job_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every comparison happens here
    int lat     = 0;
    bit lat_on  = 1'b0;
    int ld_cnt  = 0;
    bit in_done = 1'b0;
    bit idle_ck = 1'b0;

    always @(negedge clk) begin
        obs_t o;
        job_t e;
        if (lat_on) lat++;
        if (bus.mac_load_accum === 1'b1) ld_cnt++;
        if (reset_n && !bus.busy && bus.start) begin
            lat_on = 1'b1;
            lat    = 0;
            ld_cnt = 0;
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            cmp(o.nm, o.act, o.exp);
        end
        if (idle_ck) begin
            idle_ck = 1'b0;
            cmp("idle_after_done", 64'(bus.busy), 64'd0);
        end
        if (reset_n && bus.done_valid) begin
            if (exp_q.size() == 0) begin
                cmp("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = exp_q[0];
                cmp("accumulator", 64'(acc_q), e.acc);
                if (!in_done) begin
                    in_done = 1'b1;
                    cmp("done_latency", 64'(lat), 64'(e.lat));
                    cmp("load_accum_cycles", 64'(ld_cnt), 64'(e.ld));
                    if (e.pstall >= 0) cmp("perf_stall", 64'(bus.perf_stall_cycles), 64'(e.pstall));
                    if (e.pbusy >= 0)  cmp("perf_busy", 64'(bus.perf_busy_cycles), 64'(e.pbusy));
                end
                if (bus.done_ready) begin
                    void'(exp_q.pop_front());
                    in_done = 1'b0;
                    idle_ck = 1'b1;
                end
            end
        end
    end

    // Stimulus helpers
    task automatic push_obs(input string nm, input logic [63:0] act, input logic [63:0] exp);
        obs_t o;
        o.nm  = nm;
        o.act = act;
        o.exp = exp;
        obs_q.push_back(o);
    endtask

    task automatic push_job(input logic [63:0] acc, input int lt, input int ld,
                            input longint pstall, input longint pbusy);
        job_t j;
        j.acc    = acc;
        j.lat    = lt;
        j.ld     = ld;
        j.pstall = pstall;
        j.pbusy  = pbusy;
        exp_q.push_back(j);
    endtask

    task automatic reset_obs();
        push_obs("rst_mac_reset", 64'(bus.mac_reset), 64'd1);
        push_obs("rst_busy", 64'(bus.busy), 64'd0);
        push_obs("rst_in_ready", 64'(bus.in_ready), 64'd0);
        push_obs("rst_mac_en", 64'(bus.mac_en), 64'd0);
        push_obs("rst_done_valid", 64'(bus.done_valid), 64'd0);
        push_obs("rst_perf_busy", 64'(bus.perf_busy_cycles), 64'd0);
        push_obs("rst_perf_stall", 64'(bus.perf_stall_cycles), 64'd0);
    endtask

    task automatic issue(input int n, input bit ld, input int prev, input int a, input int w);
        @(posedge clk); #1;
        for (int i = 0; i < VEC_LENGTH; i++) begin
            act_v[i] = 8'(a);
            wgt_v[i] = 8'(w);
        end
        bus.start      = 1'b1;
        bus.num_chunks = 16'(n);
        bus.load_init  = ld;
        accum_prev     = 32'(prev);
        bus.in_valid   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (bus.busy && k < bound) begin
            @(posedge clk); #1;
            k++;
        end
        if (bus.busy) push_obs("timeout_idle", 64'd1, 64'd0);
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (!bus.done_valid && k < bound) begin
            @(posedge clk); #1;
            k++;
        end
        if (!bus.done_valid) push_obs("timeout_done", 64'd1, 64'd0);
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.num_chunks = '0;
        bus.load_init  = 1'b0;
        bus.in_valid   = 1'b0;
        bus.done_ready = 1'b1;
        accum_prev     = '0;
        for (int i = 0; i < VEC_LENGTH; i++) begin
            act_v[i] = '0;
            wgt_v[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset_obs();
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Chunking: 3 x (16*1*2)
        push_job(64'd96, 5, 0, -1, -1);
        issue(3, 1'b0, 0, 1, 2);
        wait_idle(50);

        // Seeded accumulator
        push_job(64'd1016, 3, 1, -1, -1);
        issue(1, 1'b1, 1000, 1, 1);
        wait_idle(50);

        // Zero chunks: seed passes straight through DRAIN
        push_job(64'd7, 2, 1, -1, -1);
        issue(0, 1'b1, 7, 0, 0);
        wait_idle(50);

        // Stalls, held done and ignored start pulses: 2 x (16*2*5)
        push_job(64'd320, 8, 0, PERF_EN ? 4 : 0, PERF_EN ? 17 : 0);
        issue(2, 1'b0, 0, 2, 5);
        bus.done_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        bus.start      = 1'b1;
        bus.num_chunks = 16'd5;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b1;
        wait_done(20);
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        bus.done_ready = 1'b1;
        wait_idle(50);

        // Reset mid-RUN with residue in the MAC pipeline
        issue(4, 1'b0, 0, 3, 3);
        @(posedge clk);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        reset_obs();
        @(posedge clk); #1;
        reset_n = 1'b1;
        push_job(64'd16, 3, 0, 0, PERF_EN ? 2 : 0);
        issue(1, 1'b0, 0, 1, 1);
        wait_idle(50);

        repeat (3) @(negedge clk);
        push_obs("pending_jobs", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_parallel_ctrl.md
MAC_PARALLEL_CTRL -- requirements
Module: mac_parallel_ctrl

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of the chunk-count field.
REQ-002 Parameter PERF_WIDTH, default 32: width of the performance counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  job request; sampled only in IDLE.
REQ-006 num_chunks  input  CNT_WIDTH  number of VEC_LENGTH-wide operand chunks in the job; latched on start.
REQ-007 load_init  input  1  when 1, the job seeds the accumulator from the MAC accum_prev port; latched on start.
REQ-008 busy  output  1  high in any state other than IDLE.
REQ-009 in_valid / in_ready  input / output  1 / 1  operand-chunk handshake; the chunk is accepted when both are 1.
REQ-010 mac_en / mac_load_accum / mac_reset  output  1 each  drive the MAC's en, load_accum and synchronous active-high reset.
REQ-011 done_valid / done_ready  output / input  1 / 1  marks the MAC result as final; the result is consumed when both are 1.
REQ-012 perf_busy_cycles / perf_stall_cycles  output  PERF_WIDTH each  performance counters (see Configuration).

Function
REQ-013 The FSM SHALL have states IDLE, RUN, DRAIN and DONE, encoded 2-bit.
REQ-014 IDLE: mac_reset=1, mac_en=0. start=1 moves to RUN, or to DRAIN if num_chunks=0.
REQ-015 RUN: in_ready=1. mac_en=in_valid. Each accepted chunk decrements the remaining count. Acceptance of the last chunk moves to DRAIN.
REQ-016 DRAIN: lasts exactly 1 cycle with mac_en=1 and in_ready=0. It flushes the MAC pipeline register into the accumulator, then moves to DONE.
REQ-017 DONE: done_valid=1, mac_en=0, so the MAC result holds stable. done_ready=1 moves to IDLE.
REQ-018 mac_load_accum SHALL equal load_init on the first mac_en cycle of a job and 0 otherwise. With zero chunks, that first cycle is the DRAIN cycle.
REQ-019 RUN with in_valid=0 is a stall: the MAC holds and the count is unchanged. There is no timeout.
REQ-020 start in any state other than IDLE SHALL be ignored. in_valid outside RUN SHALL be ignored.
REQ-021 With no stalls, done_valid SHALL rise N+2 cycles after the start-sampling edge (N = num_chunks).
REQ-022 in_ready, mac_en, mac_load_accum, mac_reset, busy and done_valid are combinational from state and inputs. No output SHALL depend combinationally on done_ready.
REQ-023 Back-to-back jobs SHALL pass through IDLE for at least 1 cycle, so that mac_reset clears stale pipeline contents.

Reset
REQ-024 Asserting reset_n low SHALL force IDLE and clear the count and latched fields asynchronously, including mid-job.
REQ-025 While reset_n is low: mac_reset=1, busy=0, in_ready=0, mac_en=0, done_valid=0, and both perf counters are 0.

Configuration
REQ-026 When macro MAC_CTRL_PERF_CNT_EN is defined:
- perf_busy_cycles increments every non-IDLE cycle.
- perf_stall_cycles increments every RUN cycle with in_valid=0.
- Both counters saturate at all-ones and clear only on reset.
REQ-027 When MAC_CTRL_PERF_CNT_EN is undefined, both counter outputs SHALL be tied to 0, with no counter flops.

Structure
REQ-028 The shared package SHALL hold the state enum typedef (IDLE, RUN, DRAIN, DONE) and the defaults for CNT_WIDTH and PERF_WIDTH.
REQ-029 The block SHALL be one flat module with no sub-module. Operand buses connect from source to MAC directly and do not pass through this block.

Verification
REQ-030 Bench with a reference MAC (VEC_LENGTH=16). Directed scenarios:
- Chunking: num_chunks=3, load_init=0, all act=1, w=2, in_valid held 1 -> done_valid after 5 cycles, accumulator=96.
- Accumulator seeding: num_chunks=1, load_init=1, accum_prev=1000, act=w=1 -> accumulator=1016, mac_load_accum high for exactly 1 cycle.
- Zero chunks: num_chunks=0, load_init=1, accum_prev=7 -> DRAIN on the next cycle, accumulator=7, done_valid 2 cycles after start.
- Stalls and start rejection: num_chunks=2, in_valid low for 4 cycles between the chunks, done_ready held 0 for 3 cycles -> result unchanged, perf_stall_cycles=4 with the macro and 0 without; start pulses during the job are ignored.
- Reset mid-job: reset_n low mid-RUN -> IDLE immediately, mac_reset=1; a following job with num_chunks=1 and act=w=1 -> accumulator=16, no residue.
